// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage pipeline: opcodes, instruction field positions and the
// interlock FSM state type.
package pipeline_pkg;

    localparam logic [4:0] OP_CMP      = 5'b00101;
    localparam logic [4:0] OP_NOT      = 5'b01000;
    localparam logic [4:0] OP_MOV      = 5'b01001;
    localparam logic [4:0] OP_ALU_LAST = 5'b01100;
    localparam logic [4:0] OP_NOP      = 5'b01101;
    localparam logic [4:0] OP_LD       = 5'b01110;
    localparam logic [4:0] OP_ST       = 5'b01111;
    localparam logic [4:0] OP_BEQ      = 5'b10000;
    localparam logic [4:0] OP_BGT      = 5'b10001;
    localparam logic [4:0] OP_B        = 5'b10010;
    localparam logic [4:0] OP_CALL     = 5'b10011;
    localparam logic [4:0] OP_RET      = 5'b10100;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned IMM_BIT = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_MSB = 21;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_MSB = 17;
    localparam int unsigned RS2_LSB = 14;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_t;

    // Opcodes 00000..01100 are the register/immediate ALU group (cmp, not and mov included).
    function automatic logic is_alu_op(input logic [4:0] op);
        return op <= OP_ALU_LAST;
    endfunction

endpackage

// File: rtl/pipeline_interlock_unit_src_reg_decode.sv
// Combinational source-register decode: which register operands an instruction reads.
module src_reg_decode
    import pipeline_pkg::*;
#(
    parameter logic [3:0] RA_REG = 4'b1111
) (
    input  logic [31:0] i_ir,
    output logic        o_uses_rs1,
    output logic [3:0]  o_src1,
    output logic        o_uses_rs2,
    output logic [3:0]  o_src2
);

    logic [4:0] w_op;
    logic [3:0] w_rd;
    logic [3:0] w_rs1;
    logic [3:0] w_rs2;
    logic       w_imm;

    assign w_op  = i_ir[OPC_MSB:OPC_LSB];
    assign w_rd  = i_ir[RD_MSB:RD_LSB];
    assign w_rs1 = i_ir[RS1_MSB:RS1_LSB];
    assign w_rs2 = i_ir[RS2_MSB:RS2_LSB];
    assign w_imm = i_ir[IMM_BIT];

    always_comb begin
        o_uses_rs1 = 1'b1;
        case (w_op)
            OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV: o_uses_rs1 = 1'b0;
            default:                                               o_uses_rs1 = 1'b1;
        endcase
        o_src1 = (w_op == OP_RET) ? RA_REG : w_rs1;
        // A store's data operand comes from the rd field and travels on the second read port.
        o_uses_rs2 = (!w_imm && is_alu_op(w_op)) || (w_op == OP_ST);
        o_src2     = (w_op == OP_ST) ? w_rd : w_rs2;
    end

endmodule

// File: rtl/pipeline_interlock_unit.sv
// Hazard controller: load-use stall and taken-branch flush for the IF/OF and OF/EX registers,
// with saturating hazard counters for performance debug.
module pipeline_interlock_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter logic [3:0]  RA_REG = 4'b1111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      input_OF_IR,
    input  logic [31:0]      input_EX_IR,
    input  logic             is_branch_taken,
    output logic             stall_pc,
    output logic             stall_if_of,
    output logic             bubble_of_ex,
    output logic             flush_if_of,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] load_use_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_fl_cnt;

    logic       w_uses_rs1;
    logic [3:0] w_src1;
    logic       w_uses_rs2;
    logic [3:0] w_src2;
    logic [3:0] w_ex_rd;
    logic       w_ex_is_ld;
    logic       w_lu;
    logic       w_lu_stall;

    src_reg_decode #(
        .RA_REG(RA_REG)
    ) u_of_decode (
        .i_ir      (input_OF_IR),
        .o_uses_rs1(w_uses_rs1),
        .o_src1    (w_src1),
        .o_uses_rs2(w_uses_rs2),
        .o_src2    (w_src2)
    );

    assign w_ex_rd    = input_EX_IR[RD_MSB:RD_LSB];
    assign w_ex_is_ld = (input_EX_IR[OPC_MSB:OPC_LSB] == OP_LD);
    assign w_lu       = w_ex_is_ld && (r_state != StFlush) &&
                        ((w_uses_rs1 && (w_src1 == w_ex_rd)) ||
                         (w_uses_rs2 && (w_src2 == w_ex_rd)));
    // Only stall from RUN: in STALL the same ld already got its bubble.
    assign w_lu_stall = w_lu && (r_state == StRun);

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_of  = 1'b0;
        bubble_of_ex = 1'b0;
        flush_if_of  = 1'b0;
        if (!reset) begin
            if (is_branch_taken) begin
                flush_if_of  = 1'b1;
                bubble_of_ex = 1'b1;
            end else if (w_lu_stall) begin
                stall_pc     = 1'b1;
                stall_if_of  = 1'b1;
                bubble_of_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StRun;
            r_lu_cnt <= '0;
            r_fl_cnt <= '0;
        end else if (is_branch_taken) begin
            r_state <= StFlush;
            if (r_fl_cnt != '1) r_fl_cnt <= r_fl_cnt + CntOne;
        end else if (w_lu_stall) begin
            r_state <= StStall;
            if (r_lu_cnt != '1) r_lu_cnt <= r_lu_cnt + CntOne;
        end else begin
            r_state <= StRun;
        end
    end

    assign state          = r_state;
    assign load_use_count = r_lu_cnt;
    assign flush_count    = r_fl_cnt;

endmodule

// File: tb/tb_pipeline_interlock_unit.sv
// Self-checking bench for pipeline_interlock_unit: directed literal checks plus a randomized run
// compared every cycle against a behavioural hazard model.
module tb_pipeline_interlock_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] of_ir = '0;
    logic [31:0] ex_ir = '0;
    logic        br = 1'b0;

    logic        stall_pc, stall_if_of, bubble_of_ex, flush_if_of;
    logic [1:0]  state;
    logic [15:0] lu_cnt, fl_cnt;
    logic        n_stall_pc, n_stall_if_of, n_bubble_of_ex, n_flush_if_of;
    logic [1:0]  n_state;
    logic [3:0]  n_lu_cnt, n_fl_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_interlock_unit dut (
        .clk(clk), .reset(reset), .input_OF_IR(of_ir), .input_EX_IR(ex_ir),
        .is_branch_taken(br), .stall_pc(stall_pc), .stall_if_of(stall_if_of),
        .bubble_of_ex(bubble_of_ex), .flush_if_of(flush_if_of), .state(state),
        .load_use_count(lu_cnt), .flush_count(fl_cnt)
    );

    pipeline_interlock_unit #(.CNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .input_OF_IR(of_ir), .input_EX_IR(ex_ir),
        .is_branch_taken(br), .stall_pc(n_stall_pc), .stall_if_of(n_stall_if_of),
        .bubble_of_ex(n_bubble_of_ex), .flush_if_of(n_flush_if_of), .state(n_state),
        .load_use_count(n_lu_cnt), .flush_count(n_fl_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int i, input int rd,
                                       input int rs1, input int rs2);
        logic [31:0] ir;
        ir = '0;
        ir[31:27] = op[4:0];
        ir[26]    = i[0];
        ir[25:22] = rd[3:0];
        ir[21:18] = rs1[3:0];
        ir[17:14] = rs2[3:0];
        return ir;
    endfunction

    // Set of registers an instruction reads, straight from the ISA operand rules.
    function automatic logic [15:0] reads(input logic [31:0] ir);
        logic [15:0] m;
        int op;
        op = int'(ir[31:27]);
        m = '0;
        if (!(op inside {13, 18, 16, 17, 19, 8, 9})) begin
            if (op == 20) m[15] = 1'b1;
            else m[ir[21:18]] = 1'b1;
        end
        if (!ir[26] && op <= 12) m[ir[17:14]] = 1'b1;
        if (op == 15) m[ir[25:22]] = 1'b1;
        return m;
    endfunction

    // Behavioural model: did the previous cycle issue a stall / a flush, and event totals.
    bit m_known = 0;
    bit m_stalled = 0;
    bit m_flushed = 0;
    int m_lu = 0;
    int m_fl = 0;

    always @(negedge clk) begin
        bit hazard, e_fl, e_st;
        int e_state;
        hazard = (ex_ir[31:27] == 5'd14) && reads(of_ir)[ex_ir[25:22]] && !m_flushed;
        e_fl = !reset && br;
        e_st = !reset && !br && hazard && !m_stalled;
        e_state = m_flushed ? 2 : (m_stalled ? 1 : 0);
        if (m_known) begin
            chk("stall_pc", int'(stall_pc), int'(e_st));
            chk("stall_if_of", int'(stall_if_of), int'(e_st));
            chk("bubble_of_ex", int'(bubble_of_ex), int'(e_st || e_fl));
            chk("flush_if_of", int'(flush_if_of), int'(e_fl));
            chk("state", int'(state), e_state);
            chk("load_use_count", int'(lu_cnt), (m_lu > 65535) ? 65535 : m_lu);
            chk("flush_count", int'(fl_cnt), (m_fl > 65535) ? 65535 : m_fl);
            chk("n_bubble_of_ex", int'(n_bubble_of_ex), int'(e_st || e_fl));
            chk("n_state", int'(n_state), e_state);
            chk("n_load_use_count", int'(n_lu_cnt), (m_lu > 15) ? 15 : m_lu);
            chk("n_flush_count", int'(n_fl_cnt), (m_fl > 15) ? 15 : m_fl);
        end
        if (reset) begin
            m_known = 1; m_stalled = 0; m_flushed = 0; m_lu = 0; m_fl = 0;
        end else begin
            m_flushed = br;
            m_stalled = e_st;
            if (e_st) m_lu++;
            if (e_fl) m_fl++;
        end
    end

    task automatic drive(input logic [31:0] ex, input logic [31:0] of, input logic b,
                         input logic r);
        @(posedge clk);
        #1;
        ex_ir = ex; of_ir = of; br = b; reset = r;
        #1;
    endtask

    task automatic chk_ctl(input string name, input int st, input int fl, input int s);
        chk({name, "_stall_pc"}, int'(stall_pc), st);
        chk({name, "_stall_if_of"}, int'(stall_if_of), st);
        chk({name, "_bubble"}, int'(bubble_of_ex), int'(st != 0 || fl != 0));
        chk({name, "_flush"}, int'(flush_if_of), fl);
        chk({name, "_state"}, int'(state), s);
    endtask

    initial begin
        logic [31:0] ld3, add_dep, add_imm, st3, nop;
        ld3     = mk(14, 0, 3, 0, 0);
        add_dep = mk(0, 0, 5, 3, 2);
        add_imm = mk(0, 1, 5, 4, 3);
        st3     = mk(15, 1, 3, 4, 0);
        nop     = mk(13, 0, 0, 0, 0);
        ex_ir = ld3; of_ir = add_dep; br = 1'b0; reset = 1'b1;

        repeat (2) begin
            @(posedge clk);
            #2;
            chk_ctl("reset", 0, 0, 0);
            chk("reset_lu_cnt", int'(lu_cnt), 0);
            chk("reset_fl_cnt", int'(fl_cnt), 0);
        end
        drive(ld3, add_dep, 0, 1);
        chk_ctl("reset3", 0, 0, 0);
        drive(ld3, add_dep, 0, 0);
        chk_ctl("lu", 1, 0, 0);
        drive(ld3, add_dep, 0, 0);
        chk_ctl("lu_stall_state", 0, 0, 1);
        chk("lu_count", int'(lu_cnt), 1);
        drive(ld3, add_imm, 0, 0);
        chk_ctl("no_hazard_imm", 0, 0, 0);
        drive(ld3, st3, 0, 0);
        chk_ctl("st_hazard", 1, 0, 0);
        drive(nop, nop, 1, 0);
        chk_ctl("branch", 0, 1, 1);
        chk("branch_lu_count", int'(lu_cnt), 2);
        drive(nop, nop, 0, 0);
        chk_ctl("flush_state", 0, 0, 2);
        chk("flush_count", int'(fl_cnt), 1);
        drive(nop, nop, 0, 0);
        chk_ctl("after_flush", 0, 0, 0);
        drive(ld3, add_dep, 1, 0);
        chk_ctl("collision", 0, 1, 0);
        drive(nop, nop, 0, 0);
        chk_ctl("collision_next", 0, 0, 2);
        chk("collision_lu_count", int'(lu_cnt), 2);
        chk("collision_fl_count", int'(fl_cnt), 2);
        repeat (40) drive(ld3, add_dep, 0, 0);
        drive(nop, nop, 0, 0);
        chk("sat_narrow_lu", int'(n_lu_cnt), 15);
        chk("sat_wide_lu", int'(lu_cnt), 22);
        chk("sat_narrow_fl", int'(n_fl_cnt), 2);

        drive(nop, nop, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ex, of;
            int op;
            ex = $urandom;
            of = $urandom;
            ex[25:22] = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
            of[21:18] = 4'($urandom_range(0, 3));
            of[17:14] = 4'($urandom_range(0, 3));
            of[25:22] = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) ex[31:27] = 5'd14;
            op = $urandom_range(0, 20);
            of[31:27] = op[4:0];
            drive(ex, of, ($urandom_range(0, 6) == 0), ($urandom_range(0, 60) == 0));
        end
        drive(nop, nop, 0, 0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
